// File: rtl/double_pkg.sv
// double_pkg: shared binary64 field constants and slice helpers for the double conversion blocks.
package double_pkg;
  localparam int EXP_BIAS = 1023;
  localparam int MANT_BITS = 52;
  localparam logic [10:0] EXP_MAX = 11'd2047;
  localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
  function automatic logic f_sign(input logic [63:0] a);
    return a[63];
  endfunction
  function automatic logic [10:0] f_exp(input logic [63:0] a);
    return a[62:52];
  endfunction
  function automatic logic [51:0] f_frac(input logic [63:0] a);
    return a[51:0];
  endfunction
endpackage

// File: rtl/double_unpack.sv
// double_unpack: splits a binary64 into sign/exponent/fraction and classifies NaN, Inf, zero and denormal.
module double_unpack
  import double_pkg::*;
(
  input  logic [63:0] a_i,
  output logic        sign_o,
  output logic [10:0] exp_o,
  output logic [51:0] frac_o,
  output logic [52:0] mant_o,
  output logic        nan_o,
  output logic        inf_o,
  output logic        zero_o,
  output logic        denorm_o
);
  assign sign_o   = f_sign(a_i);
  assign exp_o    = f_exp(a_i);
  assign frac_o   = f_frac(a_i);
  assign mant_o   = {exp_o != '0, frac_o};
  assign nan_o    = (exp_o == EXP_MAX) && (frac_o != '0);
  assign inf_o    = (exp_o == EXP_MAX) && (frac_o == '0);
  assign zero_o   = (exp_o == '0) && (frac_o == '0);
  assign denorm_o = (exp_o == '0) && (frac_o != '0);
endmodule

// File: rtl/double_to_long.sv
// double_to_long: 3-stage binary64 -> int64 converter, truncating toward zero and saturating on overflow.
module double_to_long
  import double_pkg::*;
#(
  parameter logic [63:0] NAN_RESULT = 64'h8000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_a,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_overflow,
  output logic        out_invalid
);
  localparam logic [10:0] E_ONE    = 11'(EXP_BIAS);
  localparam logic [10:0] E_UNIT   = 11'(EXP_BIAS + MANT_BITS);
  localparam logic [10:0] E_BIG    = 11'(EXP_BIAS + 63);
  localparam logic [10:0] E_RCLAMP = E_UNIT - 11'd63;
  logic        adv;
  logic        s, nan, inf, zero, denorm;
  logic [10:0] e;
  logic [51:0] f;
  logic [52:0] m;
  logic        big_d, small_d, min_d, left_d;
  logic [5:0]  sh_d;
  logic [63:0] mag_d, z_d;
  logic        ovf_d;
  logic        v1_q, s1_q, nan1_q, big1_q, small1_q, min1_q, left1_q;
  logic [52:0] m1_q;
  logic [5:0]  sh1_q;
  logic        v2_q, s2_q, nan2_q, big2_q, min2_q;
  logic [63:0] mag2_q;
  logic        v3_q, ovf3_q, inv3_q;
  logic [63:0] z3_q;
  double_unpack u_unpack (
    .a_i      (in_a),
    .sign_o   (s),
    .exp_o    (e),
    .frac_o   (f),
    .mant_o   (m),
    .nan_o    (nan),
    .inf_o    (inf),
    .zero_o   (zero),
    .denorm_o (denorm)
  );
  assign adv          = out_ready | ~v3_q;
  assign in_ready     = adv;
  assign out_valid    = v3_q;
  assign out_z        = z3_q;
  assign out_overflow = ovf3_q;
  assign out_invalid  = inv3_q;
  always_comb begin
    big_d   = (e >= E_BIG) | inf | nan;
    small_d = zero | denorm | (e < E_ONE);
    min_d   = s & (e == E_BIG) & (f == '0);
    left_d  = e >= E_UNIT;
    // only the low 6 bits of a left shift matter: anything past 10 is already saturated by big
    sh_d    = left_d ? 6'(e - E_UNIT) : (e <= E_RCLAMP ? 6'd63 : 6'(E_UNIT - e));
    mag_d   = small1_q ? '0 : left1_q ? {11'b0, m1_q} << sh1_q : {11'b0, m1_q} >> sh1_q;
    z_d     = nan2_q ? NAN_RESULT : min2_q ? INT64_MIN : big2_q ? (s2_q ? INT64_MIN : INT64_MAX) :
              s2_q ? -mag2_q : mag2_q;
    ovf_d   = ~nan2_q & big2_q & ~min2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      s1_q     <= 1'b0;
      nan1_q   <= 1'b0;
      big1_q   <= 1'b0;
      small1_q <= 1'b0;
      min1_q   <= 1'b0;
      left1_q  <= 1'b0;
      m1_q     <= '0;
      sh1_q    <= '0;
      v2_q     <= 1'b0;
      s2_q     <= 1'b0;
      nan2_q   <= 1'b0;
      big2_q   <= 1'b0;
      min2_q   <= 1'b0;
      mag2_q   <= '0;
      v3_q     <= 1'b0;
      z3_q     <= '0;
      ovf3_q   <= 1'b0;
      inv3_q   <= 1'b0;
    end else if (adv) begin
      v1_q     <= in_valid;
      s1_q     <= s;
      nan1_q   <= nan;
      big1_q   <= big_d;
      small1_q <= small_d;
      min1_q   <= min_d;
      left1_q  <= left_d;
      m1_q     <= m;
      sh1_q    <= sh_d;
      v2_q     <= v1_q;
      s2_q     <= s1_q;
      nan2_q   <= nan1_q;
      big2_q   <= big1_q;
      min2_q   <= min1_q;
      mag2_q   <= mag_d;
      v3_q     <= v2_q;
      z3_q     <= z_d;
      ovf3_q   <= ovf_d;
      inv3_q   <= nan2_q;
    end
  end
endmodule

// File: doc/double_to_long.md
Name: double_to_long

Overview:
- Converts an IEEE-754 binary64 value to a signed 64-bit integer, rounding toward zero and saturating on overflow.
- Sits directly downstream of double_trunc: it consumes the integral-valued double that double_trunc produces. It also accepts any raw double, since it applies its own truncation.
- 3-stage pipeline with a valid/ready handshake on both sides; it feeds the integer datapath.

Parameters:
- NAN_RESULT, 64'h8000000000000000, integer produced for NaN inputs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_a  input  64  binary64 operand.
- in_valid  input  1  in_a is valid this cycle.
- in_ready  output  1  block accepts in_a this cycle.
- out_z  output  64  two's-complement result.
- out_valid  output  1  out_z and the flags are valid.
- out_ready  input  1  consumer accepts out_z.
- out_overflow  output  1  |value| was out of int64 range; the result is saturated.
- out_invalid  output  1  input was NaN.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits clear.
  - out_valid=0, out_z=0, out_overflow=0, out_invalid=0.
  - in_ready=1 once rst is deasserted.
- Handshake:
  - advance = out_ready | ~out_valid.
  - in_ready = advance.
  - A transfer occurs when in_valid & in_ready.
  - Every stage register loads only when advance=1; otherwise all stages hold, including out_z and the flags.
  - There is no bubble collapsing.
- Latency: 3 cycles from input acceptance to out_valid with out_ready held high. Throughput is 1 per cycle.
- Stage 1 (unpack/classify):
  - s = a[63], e = a[62:52], f = a[51:0].
  - m = {e!=0, f} (53 bits).
  - nan = (e==2047 & f!=0).
  - big = (e>=1086) | (e==2047).
  - small = (e<1023); this covers zero and denormals.
  - Register the shift direction and amount: left by e-1075 when e>=1075, right by 1075-e otherwise. Clamp right shifts to 63.
- Stage 2 (shift): mag = zero-extend m to 64 bits, then shift left or right (right shift drops fraction bits = truncation). Force mag=0 if small.
- Stage 3 (sign/saturate), first matching rule wins:
  - nan → out_z=NAN_RESULT, out_invalid=1, out_overflow=0.
  - big & s & e==1086 & f==0 → out_z=64'h8000000000000000, out_overflow=0. This is exactly -2^63 and is representable.
  - big & ~s → out_z=64'h7FFFFFFFFFFFFFFF, out_overflow=1. This includes +Inf.
  - big & s → out_z=64'h8000000000000000, out_overflow=1. This includes -Inf.
  - otherwise → out_z = s ? -mag : mag, both flags 0. -0.0 yields 0.
- Boundaries:
  - e=1085 gives a left shift of 10 and fits in 63 bits (max 2^63-1024).
  - e=1075 means no shift.
  - e=1023 means right shift 52, result ±1.
  - Bubbles (in_valid=0) propagate as stage valid=0; the data registers may take any value.
  - Reset mid-operation discards every in-flight item; no partial outputs appear afterwards.
  - out_ready may change at any time. out_z/out_valid stay stable while out_valid & ~out_ready.

Decomposition:
- Shared package (double_pkg): EXP_BIAS=1023, MANT_BITS=52, EXP_MAX=2047, INT64_MAX, INT64_MIN, field-slice helpers. This package is shared with double_trunc.
- One natural sub-module: double_unpack (combinational sign/exponent/mantissa extraction plus NaN/Inf/zero/denormal class). It is reusable by double_trunc and by later conversion blocks.
- Shifter and saturation logic stay inline.

Test Plan:
- Basic conversions, out_ready=1:
  - 0x400E000000000000 (3.75) → 3.
  - 0xC004000000000000 (-2.5) → 0xFFFFFFFFFFFFFFFE.
  - 0x3FE0000000000000 (0.5) → 0.
  - 0x8000000000000000 (-0.0) → 0.
  - All with flags 0 and each result 3 cycles after acceptance.
- Range edges:
  - 0x43DFFFFFFFFFFFFF → 0x7FFFFFFFFFFFFC00, overflow=0.
  - 0x43E0000000000000 (2^63) → 0x7FFFFFFFFFFFFFFF, overflow=1.
  - 0xC3E0000000000000 (-2^63) → 0x8000000000000000, overflow=0.
- Specials:
  - 0x7FF8000000000000 (NaN) → 0x8000000000000000, invalid=1.
  - 0xFFF0000000000000 (-Inf) → 0x8000000000000000, overflow=1.
  - 0x0000000000000001 (denormal) → 0.
- Backpressure:
  - Stream 1.0, 2.0 ... 6.0 back-to-back.
  - Hold out_ready=0 for 5 cycles once out_valid rises → out_z stays 1 and in_ready stays 0.
  - On release → 1..6 emerge in order with no loss or duplication.
- Reset mid-stream:
  - Accept 3 values, assert rst for 1 cycle → out_valid=0 and out_z=0 immediately (asynchronous).
  - No stale outputs afterwards.
  - The next input 0x4024000000000000 (10.0) → 10 after 3 cycles.
